// File: rtl/ram_wr_dispatch_if.sv
// Receive-FIFO handshake and channel RAM write bus between the USB3 FIFO and the dispatcher.
interface ram_wr_dispatch_if;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        hold;
  logic [31:0] data;
  logic [23:0] wren;

  modport master (
    output din, din_valid, hold,
    input  din_ready, data, wren
  );

  modport slave (
    input  din, din_valid, hold,
    output din_ready, data, wren
  );
endinterface

// File: rtl/ram_wr_dispatch.sv
// Parses header words from the USB3 receive FIFO and steers the following payload
// words to the addressed CA/message/auxiliary RAM, or into a per-channel code delay.
module ram_wr_dispatch #(
  parameter logic [15:0] SYNC      = 16'h5AA5,
  parameter int unsigned TO_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  ram_wr_dispatch_if.slave   bus,
  output logic [9:0]         delay_ca0,
  output logic [9:0]         delay_ca1,
  output logic [9:0]         delay_ca2,
  output logic [9:0]         delay_ca3,
  output logic [9:0]         delay_ca4,
  output logic [9:0]         delay_ca5,
  output logic [9:0]         delay_ca6,
  output logic [9:0]         delay_ca7,
  output logic               pkt_done,
  output logic               hdr_err,
  output logic               to_err
);

  localparam int unsigned IW = $clog2(TO_CYCLES + 1);
  localparam int unsigned CW = 6;
  localparam int unsigned TW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 24;

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tgt_q, tgt_d;
  logic [IW-1:0]  idle_q, idle_d, idle_inc;
  logic [DW-1:0]  data_q, data_d;
  logic [EW-1:0]  wren_q, wren_d;
  logic           pkt_q, pkt_d, hdr_q, hdr_d, to_q, to_d;
  logic [9:0]     delay_q [8];
  logic [9:0]     delay_d [8];
  logic           beat;

  assign bus.din_ready = ~rst & ~bus.hold;
  assign beat          = bus.din_valid & bus.din_ready;
  assign idle_inc      = idle_q + IW'(1);

  assign bus.data  = data_q;
  assign bus.wren  = wren_q;
  assign pkt_done  = pkt_q;
  assign hdr_err   = hdr_q;
  assign to_err    = to_q;
  assign delay_ca0 = delay_q[0];
  assign delay_ca1 = delay_q[1];
  assign delay_ca2 = delay_q[2];
  assign delay_ca3 = delay_q[3];
  assign delay_ca4 = delay_q[4];
  assign delay_ca5 = delay_q[5];
  assign delay_ca6 = delay_q[6];
  assign delay_ca7 = delay_q[7];

  // Header parse, payload steering and idle timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    idle_d  = idle_q;
    data_d  = data_q;
    wren_d  = '0;
    pkt_d   = 1'b0;
    hdr_d   = 1'b0;
    to_d    = 1'b0;
    delay_d = delay_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (bus.din[31:16] != SYNC) begin
            hdr_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
            tgt_d   = bus.din[12:8];
            idle_d  = '0;
            case (bus.din[12:11])
              2'b00:   cnt_d = CW'(32);
              2'b01:   cnt_d = CW'(47);
              default: cnt_d = CW'(1);
            endcase
          end
        end
      end
      PAYLOAD: begin
        if (beat) begin
          idle_d = '0;
          // Targets 24-31 carry a code delay instead of a RAM write
          if (tgt_q[4:3] != 2'b11) begin
            wren_d = EW'(1) << tgt_q;
            data_d = bus.din;
          end else begin
            delay_d[tgt_q[2:0]] = bus.din[9:0];
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            pkt_d   = 1'b1;
          end
        end else if (idle_inc == IW'(TO_CYCLES)) begin
          state_d = IDLE;
          to_d    = 1'b1;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      wren_q  <= '0;
      pkt_q   <= 1'b0;
      hdr_q   <= 1'b0;
      to_q    <= 1'b0;
      delay_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      pkt_q   <= pkt_d;
      hdr_q   <= hdr_d;
      to_q    <= to_d;
      delay_q <= delay_d;
    end
  end

endmodule

// File: tb/tb_ram_wr_dispatch.sv
// Directed and randomized check of ram_wr_dispatch against a packet-level reference model.
module tb_ram_wr_dispatch;
  localparam int unsigned TO = 16;
  localparam logic [15:0] SY = 16'h5AA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_wr_dispatch_if bus();
  logic [9:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic pkt_done, hdr_err, to_err;

  ram_wr_dispatch #(.SYNC(SY), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .delay_ca0(d0), .delay_ca1(d1), .delay_ca2(d2), .delay_ca3(d3),
    .delay_ca4(d4), .delay_ca5(d5), .delay_ca6(d6), .delay_ca7(d7),
    .pkt_done(pkt_done), .hdr_err(hdr_err), .to_err(to_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet in progress, words still owed, target, quiet cycles
  bit          in_pkt;
  int          rem, tgt, idle;
  logic [31:0] e_data;
  logic [23:0] e_wren;
  bit          e_pkt, e_hdr, e_to;
  logic [9:0]  e_dly [8];
  int          wr_cnt, pkt_cnt, to_cnt, hdr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit b, input logic [31:0] w);
    e_wren = '0; e_pkt = 0; e_hdr = 0; e_to = 0;
    if (r) begin
      in_pkt = 0; rem = 0; idle = 0; e_data = '0;
      for (int i = 0; i < 8; i++) e_dly[i] = '0;
    end else if (!in_pkt) begin
      if (b) begin
        if (w[31:16] != SY) e_hdr = 1;
        else begin
          in_pkt = 1;
          tgt    = int'(w[12:8]);
          rem    = (tgt < 8) ? 32 : (tgt < 16) ? 47 : 1;
          idle   = 0;
        end
      end
    end else if (b) begin
      idle = 0;
      if (tgt < 24) begin
        e_wren = 24'(1) << tgt;
        e_data = w;
      end else begin
        e_dly[tgt-24] = w[9:0];
      end
      rem--;
      if (rem == 0) begin e_pkt = 1; in_pkt = 0; end
    end else begin
      idle++;
      if (idle == TO) begin e_to = 1; in_pkt = 0; rem = 0; idle = 0; end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit h, input logic [31:0] w);
    logic [9:0] dobs [8];
    rst = r; bus.din_valid = v; bus.hold = h; bus.din = w;
    @(posedge clk);
    model(r, v && !h && !r, w);
    #1;
    dobs = '{d0, d1, d2, d3, d4, d5, d6, d7};
    chk("din_ready", 32'(bus.din_ready), 32'(!r && !h));
    chk("data", bus.data, e_data);
    chk("wren", 32'(bus.wren), 32'(e_wren));
    chk("pkt_done", 32'(pkt_done), 32'(e_pkt));
    chk("hdr_err", 32'(hdr_err), 32'(e_hdr));
    chk("to_err", 32'(to_err), 32'(e_to));
    for (int i = 0; i < 8; i++) chk($sformatf("delay_ca%0d", i), 32'(dobs[i]), 32'(e_dly[i]));
    if (bus.wren != '0) wr_cnt++;
    if (pkt_done) pkt_cnt++;
    if (to_err) to_cnt++;
    if (hdr_err) hdr_cnt++;
  endtask

  task automatic clr_counts();
    wr_cnt = 0; pkt_cnt = 0; to_cnt = 0; hdr_cnt = 0;
  endtask

  initial begin
    int k, c, quiet;
    logic [31:0] w;
    bit v;
    in_pkt = 0; rem = 0; idle = 0; tgt = 0; e_data = '0;
    for (int i = 0; i < 8; i++) e_dly[i] = '0;
    clr_counts();

    // Reset state
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);

    // 32-word CA packet to T=3, back-to-back
    clr_counts();
    step(0, 1, 0, 32'h5AA5_0300);
    for (int i = 0; i < 32; i++) step(0, 1, 0, 32'(i));
    chk("t033_writes", 32'(wr_cnt), 32);
    chk("t033_pkt_done", 32'(pkt_cnt), 1);
    chk("t033_last_data", bus.data, 32'd31);

    // 47-word message packet to T=10 with hold every 3rd cycle
    clr_counts();
    step(0, 1, 0, 32'h5AA5_0A00);
    k = 0; c = 0;
    while (k < 47) begin
      step(0, 1, (c % 3) == 2, 32'(k) | 32'h1000);
      if ((c % 3) != 2) k++;
      c++;
    end
    chk("t034_writes", 32'(wr_cnt), 47);
    chk("t034_pkt_done", 32'(pkt_cnt), 1);

    // Bad header, then delay update for channel 3
    clr_counts();
    step(0, 1, 0, 32'h1234_0000);
    step(0, 1, 0, 32'h5AA5_1B00);
    step(0, 1, 0, 32'h0000_03FF);
    step(0, 0, 0, 32'h0);
    chk("t035_hdr_err", 32'(hdr_cnt), 1);
    chk("t035_writes", 32'(wr_cnt), 0);
    chk("t035_pkt_done", 32'(pkt_cnt), 1);
    chk("t035_delay3", 32'(d3), 32'h3FF);

    // Payload timeout after 5 words, next word is a header again
    clr_counts();
    step(0, 1, 0, 32'h5AA5_0000);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'hA0 + 32'(i));
    for (int i = 0; i < TO; i++) step(0, 0, 0, 32'h0);
    chk("t036_writes", 32'(wr_cnt), 5);
    chk("t036_to_err", 32'(to_cnt), 1);
    step(0, 1, 0, 32'h1234_0000);
    step(0, 0, 0, 32'h0);
    chk("t036_reparse", 32'(hdr_cnt), 1);

    // Reset mid-packet
    clr_counts();
    step(0, 1, 0, 32'h5AA5_0900);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 32'hB0 + 32'(i));
    step(1, 1, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
    chk("t037_pkt_done", 32'(pkt_cnt), 0);
    chk("t037_to_err", 32'(to_cnt), 0);
    chk("t037_data", bus.data, 32'h0);

    // Header-looking word inside a T=2 packet is payload
    clr_counts();
    step(0, 1, 0, 32'h5AA5_0200);
    for (int i = 0; i < 32; i++) step(0, 1, 0, (i == 2) ? 32'h5AA5_0000 : 32'(i));
    chk("t038_writes", 32'(wr_cnt), 32);
    chk("t038_hdr_err", 32'(hdr_cnt), 0);
    chk("t038_pkt_done", 32'(pkt_cnt), 1);

    // Randomized traffic
    quiet = 0;
    for (int n = 0; n < 2500; n++) begin
      w = $urandom;
      if (!in_pkt && ($urandom % 3) != 0) begin
        if (($urandom % 5) != 0) w[31:16] = SY;
      end
      if (quiet > 0) quiet--;
      else if (($urandom % 120) == 0) quiet = 18;
      v = (quiet == 0) && (($urandom % 10) < 8);
      step(($urandom % 400) == 0, v, ($urandom % 4) == 0, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_wr_dispatch.md
RAM_WR_DISPATCH -- requirements
Module: ram_wr_dispatch

Interface
REQ-001 SHALL have parameters: SYNC, default 16'h5AA5, header sync pattern; TO_CYCLES, default 65535, payload idle-timeout in clk cycles.
REQ-002 SHALL have clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have din  input  32  word from the USB3 receive FIFO.
REQ-005 SHALL have din_valid  input  1  din holds a word.
REQ-006 SHALL have din_ready  output  1  dispatcher accepts din this cycle.
REQ-007 SHALL have hold  input  1  downstream pause request; a held beat is not consumed.
REQ-008 SHALL have data  output  32  word to the channel RAM write port.
REQ-009 SHALL have wren  output  24  one-hot RAM write enable: bits 0-7 CA RAMs, 8-15 message RAMs, 16-23 auxiliary.
REQ-010 SHALL have delay_ca0..delay_ca7  output  10 each  per-channel code delay.
REQ-011 SHALL have pkt_done  output  1  one-cycle pulse, last payload word written.
REQ-012 SHALL have hdr_err  output  1  one-cycle pulse, bad header dropped.
REQ-013 SHALL have to_err  output  1  one-cycle pulse, payload aborted by timeout.

Function
REQ-014 SHALL define a beat as din_valid & din_ready; din_ready = ~rst & ~hold, combinational.
REQ-015 SHALL implement states IDLE and PAYLOAD; IDLE after reset.
REQ-016 In IDLE, SHALL treat each beat as a header: sync = din[31:16], target T = din[12:8]; din[7:0], din[15:13] ignored.
REQ-017 On a header beat with sync != SYNC, SHALL pulse hdr_err next cycle, discard the word, stay in IDLE.
REQ-018 On a valid header with T in 0-7, SHALL load count 32 and enter PAYLOAD.
REQ-019 On a valid header with T in 8-15, SHALL load count 47 and enter PAYLOAD.
REQ-020 On a valid header with T in 16-23, SHALL load count 1 and enter PAYLOAD.
REQ-021 On a valid header with T in 24-31, SHALL write din[9:0]... no: SHALL enter PAYLOAD with count 1 and no wren; the single payload word's bits [9:0] load delay_ca(T-24), bits [31:10] ignored.
REQ-022 In PAYLOAD, each beat SHALL produce, one cycle later, data = din and wren = 1<<T (all zero for T>=24), for exactly one cycle.
REQ-023 wren SHALL be zero in every cycle without a registered payload beat; header words never reach data/wren-qualified writes.
REQ-024 On the final counted beat, SHALL return to IDLE and pulse pkt_done coincident with the last wren (or delay update).
REQ-025 A word equal to a header pattern inside PAYLOAD SHALL be treated as payload (no in-band escape).
REQ-026 In PAYLOAD, SHALL count consecutive cycles without a beat (hold or ~din_valid); reaching TO_CYCLES SHALL return to IDLE, pulse to_err, and discard the remaining count; words already written stay written.
REQ-027 Idle counter SHALL clear on every beat and on entry to PAYLOAD; it SHALL not run in IDLE.
REQ-028 A beat and timeout SHALL never coincide: a beat in the timeout cycle wins and clears the counter.
REQ-029 data SHALL hold its last value when wren is zero.
REQ-030 Delay outputs SHALL change only by REQ-021 and hold otherwise; downstream write-address counters are shared and wrap at 32/47, so packet ordering that keeps them aligned is the host's responsibility.

Reset
REQ-031 While rst is high: din_ready=0, state=IDLE, count and idle counter 0, data=0, wren=0, delay_ca0..7=0, pkt_done/hdr_err/to_err=0.
REQ-032 rst asserted mid-PAYLOAD SHALL abort the packet at the next edge with no further wren and no error pulse.

Verification
REQ-033 Header 0x5AA5_0300, then 32 payload words 0..31 back-to-back -> wren=0x000008 on 32 consecutive cycles with data 0..31, pkt_done on the 32nd, state IDLE.
REQ-034 Header 0x5AA5_0A00, 47 words with hold toggling every 3rd cycle -> exactly 47 wren=0x000400 pulses, no beat consumed while hold=1, pkt_done on the last.
REQ-035 Header 0x1234_0000 -> hdr_err pulse, no wren; following valid header 0x5AA5_1B00 + word 0x0000_03FF -> delay_ca3=0x3FF, wren stays 0, pkt_done pulses.
REQ-036 TO_CYCLES=16, header T=0, 5 words, then din_valid=0 for 16 cycles -> 5 wren pulses, to_err pulse, IDLE; next word is parsed as a header.
REQ-037 Header T=9, 10 words, rst high one cycle -> all outputs zero, delays zero, IDLE; no pkt_done or to_err.
REQ-038 Payload word 0x5AA5_0000 inside a T=2 packet -> written to wren bit 2, not treated as header.
